// File: rtl/instr_prefetch_queue_if.sv
// Interface bundle for the instruction prefetch queue.
// It carries the instruction-memory request/response path and the decode-side valid/ready path.
interface instr_prefetch_queue_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic            imem_req_out;
    logic [XLEN-1:0] imem_addr_out;
    logic            imem_gnt_in;
    logic            imem_rvalid_in;
    logic [31:0]     imem_rdata_in;
    logic            flush_in;
    logic [XLEN-1:0] flush_pc_in;
    logic            instr_valid_out;
    logic [31:0]     instr_out;
    logic [XLEN-1:0] instr_pc_out;
    logic            instr_ready_in;
    logic            full_out;
    logic [CW-1:0]   count_out;

    modport master (
        output imem_req_out, imem_addr_out, instr_valid_out, instr_out, instr_pc_out,
               full_out, count_out,
        input  imem_gnt_in, imem_rvalid_in, imem_rdata_in, flush_in, flush_pc_in,
               instr_ready_in
    );

    modport slave (
        input  imem_req_out, imem_addr_out, instr_valid_out, instr_out, instr_pc_out,
               full_out, count_out,
        output imem_gnt_in, imem_rvalid_in, imem_rdata_in, flush_in, flush_pc_in,
               instr_ready_in
    );
endinterface

// File: rtl/instr_prefetch_queue.sv
// Sequential instruction fetch front end: credit-limited request issue, in-order response FIFO
// with PCs, and flush redirect that drains stale in-flight responses.
module instr_prefetch_queue #(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    instr_prefetch_queue_if.master bus,
    output logic [0:0]             dbg_state
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    localparam logic [0:0] RUN   = 1'b0;
    localparam logic [0:0] DRAIN = 1'b1;

    logic [0:0]      state;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] resp_pc;
    logic [CW-1:0]   count;
    logic [CW-1:0]   outstanding;
    logic [CW-1:0]   stale;
    logic [PW-1:0]   wptr;
    logic [PW-1:0]   rptr;
    logic [31:0]     data_mem [DEPTH];
    logic [XLEN-1:0] pc_mem   [DEPTH];

    logic            credit_ok;
    logic            req;
    logic            grant;
    logic            resp_live;
    logic            resp_stale;
    logic            push;
    logic            pop;
    logic [CW-1:0]   outstanding_next;
    logic [CW-1:0]   stale_next;
    logic [XLEN-1:0] flush_pc_aligned;

    // Every FIFO entry is either filled or owed by an outstanding fetch, so issuing only
    // while count + outstanding < DEPTH means a response can never find the FIFO full.
    assign credit_ok = ({1'b0, count} + {1'b0, outstanding}) < (CW + 1)'(DEPTH);

    assign req        = !rst_in && (state == RUN) && !bus.flush_in && credit_ok;
    assign grant      = req && bus.imem_gnt_in;
    assign resp_live  = (state == RUN) && bus.imem_rvalid_in && (outstanding != '0);
    assign resp_stale = (state == DRAIN) && bus.imem_rvalid_in && (stale != '0);

    // Decode handshake: the head is transferred on any cycle with instr_valid_out && instr_ready_in;
    // valid never depends on ready, and a flush cancels that cycle's transfer.
    assign push = resp_live && !bus.flush_in;
    assign pop  = !rst_in && (count != '0) && bus.instr_ready_in && !bus.flush_in;

    assign outstanding_next = outstanding + CW'(grant) - CW'(resp_live);
    assign stale_next       = stale - CW'(resp_stale) + (bus.flush_in ? outstanding_next : '0);
    assign flush_pc_aligned = {bus.flush_pc_in[XLEN-1:2], 2'b00};

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state       <= RUN;
            fetch_pc    <= {RESET_PC[XLEN-1:2], 2'b00};
            resp_pc     <= {RESET_PC[XLEN-1:2], 2'b00};
            count       <= '0;
            outstanding <= '0;
            stale       <= '0;
            wptr        <= '0;
            rptr        <= '0;
        end else if (bus.flush_in) begin
            // In-flight fetches become stale and are dropped as they return.
            fetch_pc    <= flush_pc_aligned;
            resp_pc     <= flush_pc_aligned;
            count       <= '0;
            wptr        <= '0;
            rptr        <= '0;
            outstanding <= '0;
            stale       <= stale_next;
            state       <= (stale_next != '0) ? DRAIN : RUN;
        end else begin
            if (grant) begin
                fetch_pc <= fetch_pc + XLEN'(4);
            end
            if (push) begin
                resp_pc <= resp_pc + XLEN'(4);
                wptr    <= wptr + PW'(1);
            end
            if (pop) begin
                rptr <= rptr + PW'(1);
            end
            count       <= count + CW'(push) - CW'(pop);
            outstanding <= outstanding_next;
            stale       <= stale_next;
            if ((state == DRAIN) && (stale_next == '0)) begin
                state <= RUN;
            end
        end
    end

    always_ff @(posedge clk_in) begin
        if (!rst_in && push) begin
            data_mem[wptr] <= bus.imem_rdata_in;
            pc_mem[wptr]   <= resp_pc;
        end
    end

    assign bus.imem_req_out    = req;
    assign bus.imem_addr_out   = fetch_pc;
    assign bus.instr_valid_out = !rst_in && (count != '0);
    assign bus.instr_out       = data_mem[rptr];
    assign bus.instr_pc_out    = pc_mem[rptr];
    assign bus.full_out        = !rst_in && (count == CW'(DEPTH));
    assign bus.count_out       = rst_in ? '0 : count;
    assign dbg_state           = state;
endmodule
